lap_stopwatch: RTL and testbench

//   Parametrised stopwatch: BCD digit chain advanced by a one-cycle tick enable, plus a circular lap memory
//   the user can browse. Sits beside the clock/alarm modes and feeds the 7-segment display mux via show_bcd.
//   All logic runs on the system clock: no derived clocks, and commands act in the cycle they arrive.

---
 rtl/lap_stopwatch_pkg.sv | 25 ++
 rtl/lap_stopwatch_digit.sv | 37 +++
 rtl/lap_stopwatch.sv | 198 +++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_stopwatch_pkg.sv
// =============================================================================
// Module      : lap_stopwatch_pkg
// Description : Shared types and constants for the lap stopwatch block.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package lap_stopwatch_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2
    } sw_state_t;

    // Even digits count 0..9, odd digits 0..5, giving ss/mm/hh pairs.
    function automatic logic [BCD_W-1:0] digit_limit(input int i);
        return (i % 2 == 0) ? 4'd9 : 4'd5;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lap_stopwatch_digit.sv
// =============================================================================
// Module      : bcd_digit_counter
// Description : Single BCD digit counting 0..limit with synchronous clear.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module bcd_digit_counter
    import lap_stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [BCD_W-1:0] limit,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q == limit) ? '0 : r_q + 1'b1;
        end
    end

    assign q     = r_q;
    assign carry = (r_q == limit);

endmodule

`default_nettype wire

// File: rtl/lap_stopwatch.sv
// =============================================================================
// Module      : lap_stopwatch
// Description : BCD stopwatch with browsable circular lap memory.
//               Define LAP_STOPWATCH_SATURATE_EN to pause at all-limits time.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int LAP_DEPTH = 4,
    parameter int IDX_W     = $clog2(LAP_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    start_stop,
    input  logic                    lap,
    input  logic                    clear,
    input  logic                    view_prev,
    input  logic                    view_next,
    output logic                    running,
    output logic                    viewing,
    output logic [IDX_W-1:0]        lap_count,
    output logic [IDX_W-1:0]        view_idx,
    output logic                    ovf,
    output logic [BCD_W*DIGITS-1:0] show_bcd
);

    localparam int               c_PTR_W  = $clog2(LAP_DEPTH);
    localparam int               c_TIME_W = BCD_W * DIGITS;
    localparam logic [IDX_W-1:0] c_DEPTH  = IDX_W'(LAP_DEPTH);

    sw_state_t            r_state;
    sw_state_t            w_state_nxt;
    logic [c_TIME_W-1:0]  w_time;
    logic [DIGITS-1:0]    w_carry;
    logic [DIGITS-1:0]    w_en;
    logic                 w_clr;
    logic                 w_count;
    logic                 w_wrap;
    logic                 w_adv;
    logic                 w_sat_stop;
    logic                 w_ovf_nxt;
    logic                 w_lap_wr;

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]   w_rd_ptr;
    logic [IDX_W-1:0]     r_lap_count;
    logic [IDX_W-1:0]     w_lap_count_nxt;
    logic [IDX_W-1:0]     r_view_idx;
    logic [IDX_W-1:0]     w_view_idx_nxt;
    logic                 r_viewing;
    logic                 w_viewing_nxt;
    logic                 r_ovf;
    logic [c_TIME_W-1:0]  r_mem [LAP_DEPTH];

    // clear has no effect at all while running.
    assign w_clr    = clear & (r_state != SW_RUN);
    assign w_count  = tick & (r_state == SW_RUN);
    assign w_wrap   = w_count & (&w_carry);
    assign w_lap_wr = lap & (r_state == SW_RUN);

`ifdef LAP_STOPWATCH_SATURATE_EN
    // Set once time has parked at all-limits so the next run tick wraps instead.
    logic r_sat_done;

    assign w_sat_stop = w_wrap & ~r_sat_done;
    assign w_adv      = w_count & ~w_sat_stop;
    assign w_ovf_nxt  = w_sat_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_done <= 1'b0;
        end else if (w_clr || w_adv) begin
            r_sat_done <= 1'b0;
        end else if (w_sat_stop) begin
            r_sat_done <= 1'b1;
        end
    end
`else
    assign w_sat_stop = 1'b0;
    assign w_adv      = w_count;
    assign w_ovf_nxt  = w_wrap;
`endif

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            if (i == 0) begin : g_lsd
                assign w_en[i] = w_adv;
            end else begin : g_chain
                assign w_en[i] = w_adv & (&w_carry[i-1:0]);
            end

            bcd_digit_counter u_digit (
                .clk   (clk),
                .rst   (rst),
                .en    (w_en[i]),
                .limit (digit_limit(i)),
                .clr   (w_clr),
                .q     (w_time[BCD_W*i +: BCD_W]),
                .carry (w_carry[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SW_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SW_IDLE: begin
                if (start_stop && !w_clr) w_state_nxt = SW_RUN;
            end
            SW_RUN: begin
                if (start_stop || w_sat_stop) w_state_nxt = SW_PAUSE;
            end
            SW_PAUSE: begin
                if (w_clr)           w_state_nxt = SW_IDLE;
                else if (start_stop) w_state_nxt = SW_RUN;
            end
            default: w_state_nxt = SW_IDLE;
        endcase
    end

    // A lap write takes precedence over browsing and shifts view_idx so the
    // displayed entry stays put.
    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_lap_count_nxt = r_lap_count;
        w_viewing_nxt   = r_viewing;
        w_view_idx_nxt  = r_view_idx;
        if (w_clr) begin
            w_wr_ptr_nxt    = '0;
            w_lap_count_nxt = '0;
            w_viewing_nxt   = 1'b0;
            w_view_idx_nxt  = '0;
        end else if (w_lap_wr) begin
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (r_lap_count != c_DEPTH) w_lap_count_nxt = r_lap_count + 1'b1;
            if (r_viewing && (r_view_idx != w_lap_count_nxt - 1'b1))
                w_view_idx_nxt = r_view_idx + 1'b1;
        end else if (view_prev && !view_next) begin
            if (r_lap_count != '0) begin
                if (!r_viewing) begin
                    w_viewing_nxt  = 1'b1;
                    w_view_idx_nxt = '0;
                end else if (r_view_idx != r_lap_count - 1'b1) begin
                    w_view_idx_nxt = r_view_idx + 1'b1;
                end
            end
        end else if (view_next && !view_prev && r_viewing) begin
            if (r_view_idx == '0) w_viewing_nxt  = 1'b0;
            else                  w_view_idx_nxt = r_view_idx - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_lap_count <= '0;
            r_viewing   <= 1'b0;
            r_view_idx  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_lap_count <= w_lap_count_nxt;
            r_viewing   <= w_viewing_nxt;
            r_view_idx  <= w_view_idx_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    // Contents need no reset: nothing is readable while lap_count is zero.
    always_ff @(posedge clk) begin
        if (w_lap_wr) r_mem[r_wr_ptr] <= w_time;
    end

    assign w_rd_ptr  = r_wr_ptr - 1'b1 - r_view_idx[c_PTR_W-1:0];
    assign show_bcd  = r_viewing ? r_mem[w_rd_ptr] : w_time;
    assign running   = (r_state == SW_RUN);
    assign viewing   = r_viewing;
    assign lap_count = r_lap_count;
    assign view_idx  = r_view_idx;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
// =============================================================================
// Module      : tb_lap_stopwatch
// Description : Self-checking bench for lap_stopwatch (DIGITS=4, LAP_DEPTH=4).
//               Honours LAP_STOPWATCH_SATURATE_EN in its expectations.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_lap_stopwatch;

    localparam int DIGITS    = 4;
    localparam int LAP_DEPTH = 4;
    localparam int IDX_W     = 3;
    localparam int TOTAL     = 3600;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
    logic             view_prev = 1'b0, view_next = 1'b0;
    logic             running, viewing, ovf;
    logic [IDX_W-1:0] lap_count, view_idx;
    logic [15:0]      show_bcd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lap_stopwatch #(.DIGITS(DIGITS), .LAP_DEPTH(LAP_DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap),
        .clear(clear), .view_prev(view_prev), .view_next(view_next),
        .running(running), .viewing(viewing), .lap_count(lap_count),
        .view_idx(view_idx), .ovf(ovf), .show_bcd(show_bcd)
    );

    // Reference model: elapsed time as a plain tick count, laps as a queue.
    int m_state;   // 0 idle, 1 run, 2 pause
    int m_t;
    int m_laps[$];
    bit m_view;
    int m_idx;
    bit m_ovf;
    bit m_sat;

    function automatic void model_reset();
        m_state = 0; m_t = 0; m_laps.delete(); m_view = 0; m_idx = 0; m_ovf = 0; m_sat = 0;
    endfunction

    function automatic logic [15:0] to_bcd(input int t);
        logic [15:0] r;
        int v, base;
        r = '0;
        v = t;
        for (int i = 0; i < DIGITS; i++) begin
            base = (i % 2 == 0) ? 10 : 6;
            r[4*i +: 4] = 4'(v % base);
            v = v / base;
        end
        return r;
    endfunction

    function automatic void model_step(input bit tk, ss, lp, cl, vp, vn);
        bit run;
        int nstate;
        run    = (m_state == 1);
        nstate = m_state;
        m_ovf  = 0;
        if (cl && !run) begin
            m_t = 0; m_laps.delete(); m_view = 0; m_idx = 0; m_sat = 0; nstate = 0;
        end else begin
            if (run && lp) begin
                m_laps.push_back(m_t);
                if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_front());
                if (m_view && m_idx < m_laps.size() - 1) m_idx++;
            end else if (vp && !vn) begin
                if (m_laps.size() > 0) begin
                    if (!m_view) begin m_view = 1; m_idx = 0; end
                    else if (m_idx < m_laps.size() - 1) m_idx++;
                end
            end else if (vn && !vp && m_view) begin
                if (m_idx == 0) m_view = 0; else m_idx--;
            end
            if (run && tk) begin
                if (m_t == TOTAL - 1 && !m_sat) begin
                    m_ovf = 1;
`ifdef LAP_STOPWATCH_SATURATE_EN
                    m_sat = 1; nstate = 2;
`else
                    m_t = 0;
`endif
                end else begin
                    m_t = (m_t + 1) % TOTAL; m_sat = 0;
                end
            end
            if (ss) begin
                if (m_state == 1) nstate = 2; else nstate = 1;
            end
        end
        m_state = nstate;
    endfunction

    function automatic logic [31:0] model_pack();
        logic [15:0] b;
        b = m_view ? to_bcd(m_laps[m_laps.size() - 1 - m_idx]) : to_bcd(m_t);
        return {7'd0, b, (m_state == 1), m_view, IDX_W'(m_laps.size()), IDX_W'(m_idx), m_ovf};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {7'd0, show_bcd, running, viewing, lap_count, view_idx, ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit tk, ss, lp, cl, vp, vn);
        @(negedge clk);
        tick = tk; start_stop = ss; lap = lp; clear = cl; view_prev = vp; view_next = vn;
        model_step(tk, ss, lp, cl, vp, vn);
        @(posedge clk);
        #1;
        tick = 0; start_stop = 0; lap = 0; clear = 0; view_prev = 0; view_next = 0;
        check("model", dut_pack(), model_pack());
    endtask

    task automatic ticks(input int n);
        repeat (n) cycle(1, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit          tk, ss, lp, cl, vp, vn;
        logic [15:0] bcd;
        bit          run, view;
        logic [2:0]  lc;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{0,1,0,0,0,0, 16'h0000, 1, 0, 3'd0};
        vt[1]  = '{1,0,0,0,0,0, 16'h0001, 1, 0, 3'd0};
        vt[2]  = '{1,0,0,0,0,0, 16'h0002, 1, 0, 3'd0};
        vt[3]  = '{0,0,1,0,0,0, 16'h0002, 1, 0, 3'd1};
        vt[4]  = '{1,1,0,0,0,0, 16'h0003, 0, 0, 3'd1};
        vt[5]  = '{1,0,0,0,0,0, 16'h0003, 0, 0, 3'd1};
        vt[6]  = '{0,0,0,0,1,0, 16'h0002, 0, 1, 3'd1};
        vt[7]  = '{0,0,0,1,1,0, 16'h0000, 0, 0, 3'd0};
        vt[8]  = '{0,1,0,0,0,0, 16'h0000, 1, 0, 3'd0};
        vt[9]  = '{0,0,0,1,0,0, 16'h0000, 1, 0, 3'd0};
        vt[10] = '{1,0,0,0,0,0, 16'h0001, 1, 0, 3'd0};

        model_reset();
        #1;
        check("reset_state", dut_pack(), 32'd0);
        @(negedge clk);
        rst = 0;

        foreach (vt[k]) begin
            cycle(vt[k].tk, vt[k].ss, vt[k].lp, vt[k].cl, vt[k].vp, vt[k].vn);
            check($sformatf("vec%0d", k), {show_bcd, running, viewing, lap_count},
                  {vt[k].bcd, vt[k].run, vt[k].view, vt[k].lc});
        end

        // Run 75 ticks then pause; paused ticks are not counted.
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);   // pause -> run -> pause -> run cancels out to RUN from RUN? keep defined:
        cycle(0, 1, 0, 0, 0, 0);   // back to RUN
        cycle(0, 1, 0, 0, 0, 0);   // PAUSE
        cycle(0, 0, 0, 1, 0, 0);   // clear -> IDLE, time 0
        cycle(0, 1, 0, 0, 0, 0);   // start
        ticks(75);
        check("t75_bcd", show_bcd, 16'h0115);
        check("t75_running", running, 1'b1);
        cycle(0, 1, 0, 0, 0, 0);
        ticks(10);
        check("paused_bcd", show_bcd, 16'h0115);
        check("paused_running", running, 1'b0);

        // Laps at 5/12/20/31/40; oldest overwritten.
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        ticks(5);  cycle(0, 0, 1, 0, 0, 0);
        ticks(7);  cycle(0, 0, 1, 0, 0, 0);
        ticks(8);  cycle(0, 0, 1, 0, 0, 0);
        ticks(11); cycle(0, 0, 1, 0, 0, 0);
        ticks(9);  cycle(0, 0, 1, 0, 0, 0);
        check("lap_count_full", lap_count, 3'd4);
        cycle(0, 0, 0, 0, 1, 0); check("view0", show_bcd, 16'h0040);
        cycle(0, 0, 0, 0, 1, 0); check("view1", show_bcd, 16'h0031);
        cycle(0, 0, 0, 0, 1, 0); check("view2", show_bcd, 16'h0020);
        cycle(0, 0, 0, 0, 1, 0); check("view3", show_bcd, 16'h0012);
        cycle(0, 0, 0, 0, 1, 0); check("view_hold", {view_idx, show_bcd}, {3'd3, 16'h0012});

        // Counting continues while viewing; view_next walks out to live time.
        ticks(3);
        check("view_while_count", show_bcd, 16'h0012);
        cycle(0, 0, 0, 0, 0, 1); check("next1", show_bcd, 16'h0020);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1); check("next3", {viewing, show_bcd}, {1'b1, 16'h0040});
        cycle(0, 0, 0, 0, 0, 1); check("leave_view", {viewing, show_bcd}, {1'b0, 16'h0043});
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("view_empty", {viewing, lap_count}, {1'b0, 3'd0});

        // Count up to 59:59, then the wrapping tick.
        cycle(0, 1, 0, 0, 0, 0);
        ticks(TOTAL - 1);
        check("preload", show_bcd, 16'h5959);
        ticks(1);
`ifdef LAP_STOPWATCH_SATURATE_EN
        check("sat_hold", {show_bcd, running, ovf}, {16'h5959, 1'b0, 1'b1});
        ticks(2);
        check("sat_paused", {show_bcd, ovf}, {16'h5959, 1'b0});
        cycle(0, 1, 0, 0, 0, 0);
        ticks(1);
        check("sat_resume_wrap", {show_bcd, running, ovf}, {16'h0000, 1'b1, 1'b0});
`else
        check("wrap", {show_bcd, running, ovf}, {16'h0000, 1'b1, 1'b1});
        ticks(1);
        check("ovf_one_cycle", {show_bcd, ovf}, {16'h0001, 1'b0});
`endif

        // clear ignored in RUN, honoured in PAUSE.
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        check("clear_in_run", {running, lap_count}, {1'b1, 3'd1});
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0, 0);
        check("clear_in_pause", {show_bcd, lap_count, viewing, running}, {16'h0000, 3'd0, 1'b0, 1'b0});
        cycle(0, 1, 0, 0, 0, 0);
        ticks(7);
        cycle(1, 1, 1, 0, 0, 0);
        check("ss_lap_tick", {show_bcd, running, lap_count}, {16'h0008, 1'b0, 3'd1});
        cycle(0, 0, 0, 0, 1, 0);
        check("lap_pre_tick", show_bcd, 16'h0007);

        // Asynchronous reset mid-count.
        cycle(0, 1, 0, 0, 0, 0);
        ticks(20);
        @(negedge clk);
        tick = 1;
        #2 rst = 1;
        #1;
        check("async_rst", dut_pack(), 32'd0);
        tick = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
        cycle(0, 0, 0, 0, 0, 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            cycle($urandom_range(0, 1), ($urandom_range(0, 19) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
